// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath, with a retired-instruction counter.
// Optional feature macro CTRL_ILLEGAL_TRAP_EN: trap unknown Op/Funct into a sticky HALT state.
module mips_multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           Op,
  input  logic [5:0]           Funct,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 PCSrc,
  output logic [2:0]           ALUControl,
  output logic [1:0]           ALUSrcB,
  output logic                 ALUSrcA,
  output logic                 RegWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic [3:0]           state_o,
  output logic [CNT_WIDTH-1:0] instr_cnt_o,
  output logic                 illegal_o
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXECUTE = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state, next_state;
  logic   retire;

  // Unknown function codes fall back to add; known flags whether the trap should fire.
  function automatic logic [3:0] funct_decode(input logic [5:0] f);
    case (f)
      6'b100000: funct_decode = {1'b1, ALU_ADD};
      6'b100010: funct_decode = {1'b1, ALU_SUB};
      6'b100100: funct_decode = {1'b1, ALU_AND};
      6'b100101: funct_decode = {1'b1, ALU_OR};
      6'b101010: funct_decode = {1'b1, ALU_SLT};
      default:   funct_decode = {1'b0, ALU_ADD};
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 1'b0;
    ALUControl = ALU_ADD;
    ALUSrcB    = 2'b00;
    ALUSrcA    = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        ALUSrcB    = 2'b01;
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB = 2'b11;
        case (Op)
          OP_RTYPE:      next_state = EXECUTE;
          OP_LW, OP_SW:  next_state = MEMADR;
          OP_BEQ:        next_state = BRANCH;
          OP_ADDI:       next_state = ADDIEX;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:       next_state = HALT;
`else
          default:       next_state = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD       = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_decode(Funct)[2:0];
`ifdef CTRL_ILLEGAL_TRAP_EN
        next_state = funct_decode(Funct)[3] ? ALUWB : HALT;
`else
        next_state = ALUWB;
`endif
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        Branch     = 1'b1;
        PCSrc      = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: RegWrite = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
      HALT: next_state = HALT;
`endif
      default: next_state = FETCH;
    endcase
  end

  assign state_o = state;

  // Every completing state returns to FETCH, so retirement is a pure state decode.
  assign retire = (state == MEMWB) || (state == MEMWR) || (state == ALUWB) ||
                  (state == BRANCH) || (state == ADDIWB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instr_cnt_o <= '0;
    else if (retire) instr_cnt_o <= instr_cnt_o + 1'b1;
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       illegal_o <= 1'b0;
    else if (next_state == HALT && state != HALT)  illegal_o <= 1'b1;
  end
`else
  assign illegal_o = 1'b0;
`endif

endmodule
